// File: rtl/btn_scan_ctrl.sv
// Purpose : scans a 4x4 active-low key matrix, debounces every key and queues press events.
// Latency : press event appears on key_valid/key_code one clk after the SAMPLE cycle that produced it.
// Backpr. : one-entry event register; an event arriving while it is held unacked is dropped and flags overflow.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   scan_en         1 = scan the matrix, 0 = park it (all rows released)
//   BTN_X / BTN_Y   row drive (active-low, one row at a time) / column sense (active-low)
//   key_valid/code  held press event {row, col}; key_ack consumes it
//   key_state       debounced level per key, index {row, col}, 1 = pressed
//   overflow        sticky: at least one press event was dropped
module btn_scan_ctrl #(
    parameter int SETTLE = 1000,
    parameter int DEB_N  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    output logic [3:0]  BTN_X,
    input  logic [3:0]  BTN_Y,
    output logic        key_valid,
    output logic [3:0]  key_code,
    input  logic        key_ack,
    output logic [15:0] key_state,
    output logic        overflow
);

    localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [3:0]      DEB_LAST    = 4'(DEB_N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE
    } state_t;

    state_t        state;
    logic [1:0]    row;
    logic [SW-1:0] settle_cnt;
    logic [3:0]    deb_cnt [16];

    logic [3:0]    raw_lvl;
    logic [3:0]    row_flip;
    logic [3:0]    row_press;
    logic [3:0]    cnt_nxt [4];
    logic [1:0]    press_col;
    logic          multi_press;
    logic          do_sample;
    logic          new_evt;
    logic [1:0]    row_nxt;

    assign raw_lvl   = ~BTN_Y;
    assign row_nxt   = row + 2'd1;
    // A SAMPLE cycle with scan_en low is abandoned: no capture, straight to IDLE.
    assign do_sample = (state == S_SAMPLE) && scan_en;

    // Debounce decision for the four keys of the row being sampled.
    // A key flips once its mismatch run reaches DEB_N, so the counter
    // tops out at DEB_N-1 and can never wrap.
    always_comb begin
        row_flip = '0;
        for (int c = 0; c < 4; c++) begin
            cnt_nxt[c] = '0;
            if (raw_lvl[c] != key_state[{row, 2'(c)}]) begin
                if (deb_cnt[{row, 2'(c)}] >= DEB_LAST) begin
                    row_flip[c] = 1'b1;
                end else begin
                    cnt_nxt[c] = deb_cnt[{row, 2'(c)}] + 4'd1;
                end
            end
        end
    end

    // Only 0->1 flips are presses; the lowest column wins when several coincide.
    always_comb begin
        row_press = row_flip & raw_lvl;
        press_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (row_press[c]) begin
                press_col = 2'(c);
            end
        end
        multi_press = (row_press & (row_press - 4'd1)) != 4'd0;
        new_evt     = do_sample && (row_press != 4'd0);
    end

    // Scan FSM, row drive, debounce state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            row        <= 2'd0;
            settle_cnt <= '0;
            BTN_X      <= 4'b1111;
            key_state  <= 16'h0000;
            for (int i = 0; i < 16; i++) begin
                deb_cnt[i] <= 4'd0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (scan_en) begin
                        state      <= S_DRIVE;
                        row        <= 2'd0;
                        settle_cnt <= '0;
                        BTN_X      <= 4'b1110;
                    end
                end
                S_DRIVE: begin
                    if (!scan_en) begin
                        state      <= S_IDLE;
                        settle_cnt <= '0;
                        BTN_X      <= 4'b1111;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state      <= S_SAMPLE;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                S_SAMPLE: begin
                    if (!scan_en) begin
                        state <= S_IDLE;
                        BTN_X <= 4'b1111;
                    end else begin
                        for (int c = 0; c < 4; c++) begin
                            deb_cnt[{row, 2'(c)}]   <= cnt_nxt[c];
                            key_state[{row, 2'(c)}] <= key_state[{row, 2'(c)}] ^ row_flip[c];
                        end
                        row   <= row_nxt;
                        state <= S_DRIVE;
                        BTN_X <= ~(4'b0001 << row_nxt);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    BTN_X <= 4'b1111;
                end
            endcase
        end
    end

    // One-entry event register. An ack in the same cycle as a new event
    // frees the slot, so the new event replaces the old one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            overflow  <= 1'b0;
        end else begin
            if (new_evt) begin
                if (multi_press) begin
                    overflow <= 1'b1;
                end
                if (!key_valid || key_ack) begin
                    key_valid <= 1'b1;
                    key_code  <= {row, press_col};
                end else begin
                    overflow <= 1'b1;
                end
            end else if (key_valid && key_ack) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/btn_scan_ctrl.md
BTN_SCAN_CTRL -- requirements
Module: btn_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1000: clk cycles a row is held driven before its columns are sampled (minimum 1).
REQ-002 SHALL have parameter DEB_N, default 4: consecutive identical samples of a key needed to change its debounced state (minimum 1, maximum 15).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port scan_en  input  1  1 = scanning active, 0 = matrix parked.
REQ-006 SHALL have port BTN_X  output  4  row drive, active-low, at most one bit low at any time.
REQ-007 SHALL have port BTN_Y  input  4  column sense, active-low (0 = key closed on the driven row).
REQ-008 SHALL have port key_valid  output  1  a press event is held in the event register.
REQ-009 SHALL have port key_code  output  4  held event, {row[1:0], col[1:0]}.
REQ-010 SHALL have port key_ack  input  1  consumer accepts the event; meaningful only while key_valid=1.
REQ-011 SHALL have port key_state  output  16  debounced level per key, bit index {row, col}, 1 = pressed.
REQ-012 SHALL have port overflow  output  1  sticky flag: at least one press event was dropped.

Function
REQ-013 SHALL implement a scan FSM with three states:
- IDLE: BTN_X=4'b1111.
- DRIVE: BTN_X row r low; settle counter counts SETTLE cycles.
- SAMPLE: one cycle; row r still driven.
REQ-014 SHALL move from IDLE to DRIVE on the first cycle scan_en=1, starting at row 0 with the settle counter cleared.
REQ-015 SHALL move from DRIVE to SAMPLE after SAMPLE-free DRIVE lasts exactly SETTLE cycles, so each row occupies SETTLE+1 cycles.
REQ-016 SHALL, in SAMPLE, capture ~BTN_Y as the raw levels of row r, advance r (wrapping 3 to 0) and return to DRIVE.
REQ-017 SHALL go to IDLE on the cycle after scan_en falls, from any state, without sampling.
REQ-018 SHALL retain key_state, the debounce counters and the event register while in IDLE.
REQ-019 SHALL restart at row 0 when scan_en rises again.
REQ-020 SHALL keep a per-key count of consecutive samples whose raw level differs from key_state.
- Count clears on any sample equal to key_state.
- When the count reaches DEB_N, the key_state bit toggles and the count clears.
- The count saturates and never wraps.
REQ-021 SHALL generate a press event only on a 0-to-1 key_state transition; releases generate no event.
REQ-022 SHALL, when several keys of one row reach a press event in the same SAMPLE, accept only the lowest column index and set overflow.
REQ-023 SHALL handle the event register as follows:
- Empty, or key_ack=1 in the same cycle as an event: load key_code and set key_valid=1 on the next edge.
- key_valid=1, key_ack=0 and a new event arrives: drop the new event, keep key_code and set overflow.
- key_valid=1, key_ack=1 and no new event: clear key_valid.
REQ-024 SHALL present a new event at key_valid/key_code one cycle after the SAMPLE cycle that produced it.
REQ-025 SHALL ignore key_ack while key_valid=0.
REQ-026 SHALL make key_state update on the same edge as the event that causes it.
REQ-027 SHALL clear overflow only by reset.

Reset
REQ-028 SHALL, while rst=1 and independent of clk, force: FSM to IDLE, row=0, settle and debounce counters to 0, BTN_X=4'b1111, key_valid=0, key_code=4'h0, key_state=16'h0000, overflow=0.
REQ-029 SHALL, on reset assertion mid-scan or mid-debounce, discard all partial state.
REQ-030 SHALL begin scanning on the first clk edge after rst deasserts, if scan_en=1.

Verification (bench parameters SETTLE=4, DEB_N=3, 25 MHz clk)
REQ-031 SHALL cover: assert rst mid-scan with a key mid-debounce -> immediately BTN_X=1111, key_valid=0, key_state=0, overflow=0.
REQ-032 SHALL cover: scan_en=1, BTN_Y=4'b1011 whenever BTN_X=4'b1101 -> rows cycle every 5 clk; after the 3rd SAMPLE of row 1: key_valid=1, key_code=4'h6, key_state[6]=1; key_valid held until key_ack.
REQ-033 SHALL cover: key (row 1, col 2) closed for 2 row-1 samples, then open -> no event, key_state stays 0.
REQ-034 SHALL cover: events 4'h6 then 4'h9 with no ack -> key_code stays 4'h6, overflow=1.
REQ-035 SHALL cover: key_ack asserted in the same cycle event 4'h9 arrives while 4'h6 is held -> key_valid stays 1, key_code=4'h9, overflow=0.
REQ-036 SHALL cover: scan_en dropped during DRIVE of row 2 -> BTN_X=1111 next cycle; on scan_en rising, BTN_X=1110 on the next cycle.
